// File: rtl/alt_vipitc130_common_pkg.sv
// Shared constants and helpers for the VIP ITC trigger queue.
// Provides clog2, the index-width helper and the CHANNELS/COUNT_WIDTH defaults.
package alt_vipitc130_common_pkg;

  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_COUNT_WIDTH = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >>> 1;
    end
    return result;
  endfunction

  // A channel index always needs at least one bit, even when there is a single channel.
  function automatic int idx_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/alt_vipitc130_common_rr_arbiter.sv
// Round-robin selector: picks the first requesting channel at or above ptr,
// wrapping from CHANNELS-1 back to 0.
module alt_vipitc130_common_rr_arbiter
  import alt_vipitc130_common_pkg::*;
#(
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int IDX_W    = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  int cand;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    // Scan from the farthest offset down so the nearest requester is written last.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (req[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alt_vipitc130_common_trigger_queue.sv
// Per-channel trigger counter with a round-robin output register.
// Define ALT_VIPITC_TRIGGER_QUEUE_OVF_EN to build the sticky overflow flags.
module alt_vipitc130_common_trigger_queue
  import alt_vipitc130_common_pkg::*;
#(
  parameter  int CHANNELS         = DEFAULT_CHANNELS,
  parameter  int COUNT_WIDTH      = DEFAULT_COUNT_WIDTH,
  parameter  int RETRIGGER_ON_ACK = 1,
  localparam int IDX_W            = idx_width(CHANNELS)
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] trigger_in,
  input  logic [CHANNELS-1:0] ack_in,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_chan,
  input  logic                out_ready,
  input  logic                clear_ovf,
  output logic [CHANNELS-1:0] overflow
);

  localparam logic [COUNT_WIDTH-1:0] PMAX = '1;

  logic [CHANNELS-1:0]    trig_q, trig_d;
  logic [COUNT_WIDTH-1:0] count_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] count_d [CHANNELS];
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [IDX_W-1:0]       out_chan_q, out_chan_d;

  logic [CHANNELS-1:0] retrig, evt, req, at_max, grant;
  logic                arb_valid, load;
  logic [IDX_W-1:0]    arb_idx;

  always_comb begin
    trig_d = trigger_in;
    retrig = (RETRIGGER_ON_ACK != 0) ? ack_in : '0;
    evt    = trigger_in & (~trig_q | retrig);
    req    = '0;
    at_max = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      req[i]    = (count_q[i] != '0);
      at_max[i] = (count_q[i] == PMAX);
    end
  end

  alt_vipitc130_common_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // Loading the output register is the grant itself.
  assign load = (~out_valid_q | out_ready) & arb_valid;

  always_comb begin
    grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant[i]   = load && (arb_idx == IDX_W'(i));
      count_d[i] = count_q[i];
      if (evt[i] && !grant[i] && !at_max[i]) count_d[i] = count_q[i] + 1'b1;
      else if (grant[i] && !evt[i])          count_d[i] = count_q[i] - 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_chan_d  = arb_idx;
      ptr_d       = (arb_idx == IDX_W'(CHANNELS - 1)) ? '0 : arb_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      trig_q      <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      // NOTE: the counter array is reset explicitly; pending triggers must not
      // survive a reset, so it cannot be left as an unreset memory.
      for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
    end else begin
      trig_q      <= trig_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      for (int i = 0; i < CHANNELS; i++) count_q[i] <= count_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

`ifdef ALT_VIPITC_TRIGGER_QUEUE_OVF_EN
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  // A dropped event wins over a same-cycle clear.
  always_comb ovf_d = (ovf_q & ~{CHANNELS{clear_ovf}}) | (evt & ~grant & at_max);

  always_ff @(posedge clock) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  logic unused_clear_ovf;
  assign unused_clear_ovf = clear_ovf;
  assign overflow         = '0;
`endif

endmodule

// File: tb/tb_alt_vipitc130_common_trigger_queue.sv
// Directed bench for the trigger queue: one retriggering DUT with 2-bit counters
// plus a non-retriggering twin on the same inputs for the ack comparison.
module tb_alt_vipitc130_common_trigger_queue;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [3:0] trigger_in, ack_in;
  logic       out_ready, clear_ovf;
  logic       out_valid, out_valid_nr;
  logic [1:0] out_chan, out_chan_nr;
  logic [3:0] overflow, overflow_nr;

  int tests    = 0;
  int failures = 0;

`ifdef ALT_VIPITC_TRIGGER_QUEUE_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  always #5 clock = ~clock;

  alt_vipitc130_common_trigger_queue #(
    .CHANNELS (4), .COUNT_WIDTH (2), .RETRIGGER_ON_ACK (1)
  ) dut (
    .clock (clock), .rst_n (rst_n), .trigger_in (trigger_in), .ack_in (ack_in),
    .out_valid (out_valid), .out_chan (out_chan), .out_ready (out_ready),
    .clear_ovf (clear_ovf), .overflow (overflow)
  );

  alt_vipitc130_common_trigger_queue #(
    .CHANNELS (4), .COUNT_WIDTH (2), .RETRIGGER_ON_ACK (0)
  ) dut_nr (
    .clock (clock), .rst_n (rst_n), .trigger_in (trigger_in), .ack_in (ack_in),
    .out_valid (out_valid_nr), .out_chan (out_chan_nr), .out_ready (out_ready),
    .clear_ovf (clear_ovf), .overflow (overflow_nr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after a rising edge: outputs are settled, inputs may change.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    trigger_in = '0;
    ack_in     = '0;
    out_ready  = 1'b0;
    clear_ovf  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_rt, n_nr, bad_chan;

    // Reset state
    do_reset();
    check("rst_valid",    out_valid, 0);
    check("rst_chan",     out_chan,  0);
    check("rst_overflow", overflow,  0);
    check("rst_valid_nr", out_valid_nr, 0);

    // Single pulse on channel 2: presented only in cycle c+2
    out_ready  = 1'b1;
    trigger_in = 4'b0100;
    check("pulse_c0_valid", out_valid, 0);
    tick();
    trigger_in = 4'b0000;
    check("pulse_c1_valid", out_valid, 0);
    tick();
    check("pulse_c2_valid", out_valid, 1);
    check("pulse_c2_chan",  out_chan,  2);
    tick();
    check("pulse_c3_valid", out_valid, 0);

    // Round robin: 0,1,3 together, then a later 0 must follow 3
    do_reset();
    out_ready  = 1'b1;
    trigger_in = 4'b1011;
    tick();
    trigger_in = 4'b0000;
    tick();
    check("rr_0_valid", out_valid, 1);
    check("rr_0_chan",  out_chan,  0);
    trigger_in = 4'b0001;
    tick();
    trigger_in = 4'b0000;
    check("rr_1_chan", out_chan, 1);
    tick();
    check("rr_3_chan", out_chan, 3);
    tick();
    check("rr_0b_valid", out_valid, 1);
    check("rr_0b_chan",  out_chan,  0);
    tick();
    check("rr_empty_valid", out_valid, 0);

    // Saturation: PMAX=3, output register holds one, the fifth pulse overflows
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      trigger_in = 4'b0010;
      tick();
      trigger_in = 4'b0000;
      tick();
      if (p == 3) check("sat_no_ovf_at_4", overflow[1], 0);
    end
    check("sat_ovf1",       overflow[1], EXP_OVF);
    check("sat_ovf_others", {overflow[3:2], overflow[0]}, 0);
    check("sat_hold_valid", out_valid, 1);
    check("sat_hold_chan",  out_chan,  1);
    out_ready = 1'b1;
    n_rt      = 0;
    bad_chan  = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        n_rt++;
        if (out_chan != 2'd1) bad_chan++;
      end
      tick();
    end
    check("sat_accepts",    n_rt, 4);
    check("sat_chan",       bad_chan, 0);
    check("sat_ovf_sticky", overflow[1], EXP_OVF);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("sat_ovf_clear", overflow, 0);

    // Backpressure: held for 4 cycles while channel 0 queues behind
    do_reset();
    out_ready  = 1'b0;
    trigger_in = 4'b0100;
    tick();
    trigger_in = 4'b0000;
    tick();
    trigger_in = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_chan",  out_chan,  2);
      tick();
      trigger_in = 4'b0000;
    end
    out_ready = 1'b1;
    check("bp_accept_chan", out_chan, 2);
    tick();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_chan",  out_chan,  0);
    tick();
    check("bp_drain_valid", out_valid, 0);

    // Retrigger: channel 0 held high, ack high for two cycles
    do_reset();
    out_ready = 1'b1;
    n_rt      = 0;
    n_nr      = 0;
    bad_chan  = 0;
    for (int k = 0; k < 12; k++) begin
      trigger_in = 4'b0001;
      ack_in     = (k == 2 || k == 3) ? 4'b0001 : 4'b0000;
      if (out_valid) begin
        n_rt++;
        if (out_chan != 2'd0) bad_chan++;
      end
      if (out_valid_nr) n_nr++;
      tick();
    end
    trigger_in = 4'b0000;
    ack_in     = 4'b0000;
    check("retrig_on_grants",  n_rt, 3);
    check("retrig_off_grants", n_nr, 1);
    check("retrig_chan",       bad_chan, 0);

    // Reset mid-operation discards pending work; a held trigger is re-detected
    do_reset();
    out_ready  = 1'b0;
    trigger_in = 4'b1011;
    tick();
    trigger_in = 4'b0000;
    tick();
    tick();
    check("mrst_pre_valid", out_valid, 1);
    rst_n      = 1'b0;
    trigger_in = 4'b0100;
    tick();
    rst_n = 1'b1;
    check("mrst_k1_valid", out_valid, 0);
    check("mrst_k1_chan",  out_chan,  0);
    out_ready = 1'b1;
    tick();
    check("mrst_k2_valid", out_valid, 0);
    tick();
    check("mrst_k3_valid", out_valid, 1);
    check("mrst_k3_chan",  out_chan,  2);
    trigger_in = 4'b0000;
    tick();
    check("mrst_k4_valid", out_valid, 0);
    tick();
    check("mrst_k5_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
